multi_port_rom_pipelined: RTL



---
 rtl/multi_port_rom_pipelined.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/multi_port_rom_pipelined.sv
// ---------------------------------------------------------------------------
// multi_port_rom_pipelined
//
// Purpose:
//   NUM_PORTS independent read ports over one shared ROM. The ROM contents
//   are fixed by INIT_PATTERN. Each port has a read pipeline of 0, 1 or 2
//   stages, a valid strobe, and an out-of-range address flag. There is no
//   arbitration between ports and no backpressure.
//
// Ports:
//   clk          - single clock; all flops update on the rising edge
//   reset        - asynchronous, active-high; clears all pipeline state
//   rd_en        - [NUM_PORTS] per-port read request
//   rd_addr      - [NUM_PORTS*ADDR_WIDTH] packed addresses, port p at
//                  [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data      - [NUM_PORTS*DATA_WIDTH] packed read data, port p at
//                  [p*DATA_WIDTH +: DATA_WIDTH]; zero when not valid
//   rd_valid     - [NUM_PORTS] per-port data-valid strobe
//   rd_addr_err  - [NUM_PORTS] out-of-range flag, aligned with rd_valid
//   rd_count     - [NUM_PORTS*16] per-port saturating read counters
//                  (present only when ROM_RD_CNT_EN is defined)
//
// Optional feature macro: ROM_RD_CNT_EN
// ---------------------------------------------------------------------------
module multi_port_rom_pipelined #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int MEM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int NUM_PORTS    = 4,
    parameter int READ_LATENCY = 1,
    parameter int INIT_PATTERN = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             rd_en,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_PORTS-1:0]             rd_valid,
    output logic [NUM_PORTS-1:0]             rd_addr_err
`ifdef ROM_RD_CNT_EN
    ,
    output logic [NUM_PORTS*16-1:0]          rd_count
`endif
);

    // Illegal configurations stop elaboration instead of building something
    // that silently misbehaves.
    if (READ_LATENCY < 0 || READ_LATENCY > 2) begin : g_bad_latency
        $error("multi_port_rom_pipelined: READ_LATENCY must be 0, 1 or 2");
    end
    if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
        $error("multi_port_rom_pipelined: NUM_PORTS must be in 1..8");
    end
    if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("multi_port_rom_pipelined: MEM_DEPTH must be in 1..2^ADDR_WIDTH");
    end

    // ROM word for a given address. Arithmetic is done in 32-bit integers
    // and then truncated, so wide patterns like a*a+a wrap predictably.
    function automatic logic [DATA_WIDTH-1:0] rom_word(input int a);
        int v;
        case (INIT_PATTERN)
            1:       v = a * a + a;
            2:       v = a;
            3:       v = a ^ (a >> 1);
            default: v = 0;
        endcase
        return DATA_WIDTH'(v);
    endfunction

    logic [NUM_PORTS-1:0]  req_err;
    logic [DATA_WIDTH-1:0] req_data [NUM_PORTS];

    logic [NUM_PORTS-1:0]  out_valid;
    logic [NUM_PORTS-1:0]  out_err;
    logic [DATA_WIDTH-1:0] out_data [NUM_PORTS];

    // Request decode: range check and ROM lookup for every port. The data is
    // already forced to zero for idle or out-of-range requests, so every
    // later stage only has to move it along.
    always_comb begin
        logic [ADDR_WIDTH-1:0] addr_p;
        logic                  oor;
        addr_p  = '0;
        oor     = 1'b0;
        req_err = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            addr_p      = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            oor         = (int'(addr_p) >= MEM_DEPTH);
            req_err[p]  = rd_en[p] & oor;
            req_data[p] = (rd_en[p] && !oor) ? rom_word(int'(addr_p)) : '0;
        end
    end

    if (READ_LATENCY == 0) begin : g_lat0
        // Purely combinational read; reset still forces the outputs low
        // because the output spec does not depend on registered state here.
        always_comb begin
            out_valid = reset ? '0 : rd_en;
            out_err   = reset ? '0 : req_err;
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_data[p] = reset ? '0 : req_data[p];
            end
        end
    end else if (READ_LATENCY == 1) begin : g_lat1
        // Single output register stage: a request sampled on one edge is
        // visible right after that edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_valid <= '0;
                out_err   <= '0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    out_data[p] <= '0;
                end
            end else begin
                out_valid <= rd_en;
                out_err   <= req_err;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    out_data[p] <= req_data[p];
                end
            end
        end
    end else begin : g_lat2
        logic [NUM_PORTS-1:0]  s1_en;
        logic [NUM_PORTS-1:0]  s1_err;
        logic [DATA_WIDTH-1:0] s1_data [NUM_PORTS];

        // Two-stage pipeline: stage 1 captures the looked-up request, stage 2
        // drives the outputs. Valids simply shift, so back-to-back requests
        // come out back-to-back and a reset wipes both stages at once.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_en     <= '0;
                s1_err    <= '0;
                out_valid <= '0;
                out_err   <= '0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    s1_data[p]  <= '0;
                    out_data[p] <= '0;
                end
            end else begin
                s1_en     <= rd_en;
                s1_err    <= req_err;
                out_valid <= s1_en;
                out_err   <= s1_err;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    s1_data[p]  <= req_data[p];
                    out_data[p] <= s1_data[p];
                end
            end
        end
    end

    // Flatten the per-port results onto the packed output buses.
    always_comb begin
        rd_valid    = out_valid;
        rd_addr_err = out_err;
        rd_data     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = out_data[p];
        end
    end

`ifdef ROM_RD_CNT_EN
    logic [15:0] cnt [NUM_PORTS];

    // One saturating counter per port, bumped on every delivered read,
    // including out-of-range ones; it parks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (out_valid[p] && cnt[p] != 16'hFFFF) begin
                    cnt[p] <= cnt[p] + 16'd1;
                end
            end
        end
    end

    // Pack the counters onto the rd_count bus.
    always_comb begin
        rd_count = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_count[p*16 +: 16] = cnt[p];
        end
    end
`endif

endmodule
